// File: rtl/md_unit.sv
`timescale 1ns/1ps
// Multiply/divide unit for the EX stage: mult/multu/div/divu with a fixed
// multi-cycle latency, mthi/mtlo, and ownership of the HI/LO registers.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        dbg_state
);

  // start is a one-cycle pulse accepted only while busy is low; a start seen
  // while busy is high is dropped. busy is registered and falls on the same
  // edge that commits HI/LO, so the first cycle with busy low reads the result.

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [31:0]   hi_p, lo_p;

  logic        is_signed, is_div, a_neg, b_neg, md_accept;
  logic [63:0] mul_a, mul_b, prod;
  logic [31:0] div_a, div_b, uq, ur, quo, rem;
  logic [31:0] res_hi, res_lo;

  assign md_accept = (state == IDLE) && start && !md_op[2];
  assign is_signed = !md_op[0];
  assign is_div    = md_op[1];

  // Sign-extending both operands to 64 bits makes the low half of the
  // unsigned product equal to the signed product.
  assign mul_a = is_signed ? {{32{A[31]}}, A} : {32'b0, A};
  assign mul_b = is_signed ? {{32{B[31]}}, B} : {32'b0, B};
  assign prod  = mul_a * mul_b;

  // Signed division on magnitudes; 0x80000000 / -1 naturally yields
  // quotient 0x80000000 and remainder 0 this way.
  assign a_neg = is_signed && A[31];
  assign b_neg = is_signed && B[31];
  assign div_a = a_neg ? (~A + 32'd1) : A;
  assign div_b = b_neg ? (~B + 32'd1) : B;
  assign uq    = (div_b == 32'd0) ? 32'd0 : div_a / div_b;
  assign ur    = (div_b == 32'd0) ? 32'd0 : div_a % div_b;
  assign quo   = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
  assign rem   = a_neg ? (~ur + 32'd1) : ur;

  always_comb begin
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (is_div) begin
      if (B == 32'd0) begin
        res_hi = HI;
        res_lo = LO;
      end else begin
        res_hi = rem;
        res_lo = quo;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (md_accept) state_n = RUN;
      RUN:  if (cnt == CNT_ONE) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      hi_p <= '0;
      lo_p <= '0;
      HI   <= '0;
      LO   <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        case (md_op)
          3'd0, 3'd1, 3'd2, 3'd3: begin
            hi_p <= res_hi;
            lo_p <= res_lo;
            cnt  <= is_div ? DIV_LD : MULT_LD;
          end
          3'd4:    HI <= A;
          3'd5:    LO <= A;
          default: ;
        endcase
      end
    end else begin
      cnt <= cnt - CNT_ONE;
      if (cnt == CNT_ONE) begin
        HI <= hi_p;
        LO <= lo_p;
      end
    end
  end

  assign busy      = (state == RUN);
  assign dbg_state = state;

endmodule

// File: tb/tb_md_unit.sv
`timescale 1ns/1ps
// Directed bench for md_unit: latency, results, mthi/mtlo, div-by-zero,
// ignored start while busy and asynchronous reset mid-operation.
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] op_a, op_b;
  logic        busy;
  logic [31:0] HI, LO;
  logic        dbg_state;

  int errors = 0;
  int checks = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .A(op_a), .B(op_b), .busy(busy), .HI(HI), .LO(LO), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drivers: called at a negedge, return at the next negedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    md_op = op;
    op_a  = a;
    op_b  = b;
    @(negedge clk);
    start = 1'b0;
    md_op = 3'd6;
    op_a  = 32'hDEAD_BEEF;
    op_b  = 32'hDEAD_BEEF;
  endtask

  // Counts busy cycles from the current negedge until busy drops (bounded),
  // and counts samples where HI/LO differ from the values they must hold.
  task automatic wait_done(input logic [31:0] hi_hold, input logic [31:0] lo_hold,
                           output int cyc, output int held_bad);
    cyc = 0;
    held_bad = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      if (HI !== hi_hold || LO !== lo_hold) held_bad++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    start = 1'b0;
    md_op = 3'd0;
    op_a  = 32'd0;
    op_b  = 32'd0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=0", HI); end
    checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=0", LO); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult;
    int cyc, bad;
    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    wait_done(32'd0, 32'd0, cyc, bad);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL mult_latency got=%0d exp=5", cyc); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL mult_hold got=%0d bad samples exp=0", bad); end
    checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got=%h exp=ffffffff", HI); end
    checks++; if (LO !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo got=%h exp=fffffffa", LO); end
  endtask

  task automatic test_multu_mthi;
    int cyc, bad;
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    wait_done(32'hFFFF_FFFF, 32'hFFFF_FFFA, cyc, bad);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL multu_latency got=%0d exp=5", cyc); end
    checks++; if (HI !== 32'h0000_0001) begin errors++; $display("FAIL multu_hi got=%h exp=00000001", HI); end
    checks++; if (LO !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_lo got=%h exp=fffffffe", LO); end
    issue(3'd4, 32'h1234_5678, 32'd0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got=%b exp=0", busy); end
    checks++; if (HI !== 32'h1234_5678) begin errors++; $display("FAIL mthi_hi got=%h exp=12345678", HI); end
    checks++; if (LO !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mthi_lo got=%h exp=fffffffe", LO); end
    issue(3'd6, 32'h5555_5555, 32'd1);
    checks++; if (busy !== 1'b0 || HI !== 32'h1234_5678 || LO !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL reserved_op got busy=%b hi=%h lo=%h exp busy=0 hi=12345678 lo=fffffffe", busy, HI, LO);
    end
  endtask

  task automatic test_div_back_to_back;
    int cyc, bad;
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done(32'h1234_5678, 32'hFFFF_FFFE, cyc, bad);
    checks++; if (cyc !== 10) begin errors++; $display("FAIL div_latency got=%0d exp=10", cyc); end
    checks++; if (LO !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got=%h exp=fffffffd", LO); end
    checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got=%h exp=ffffffff", HI); end
    issue(3'd3, 32'd7, 32'd2);
    wait_done(32'hFFFF_FFFF, 32'hFFFF_FFFD, cyc, bad);
    checks++; if (cyc !== 10) begin errors++; $display("FAIL divu_latency got=%0d exp=10", cyc); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL divu_hold got=%0d bad samples exp=0", bad); end
    checks++; if (LO !== 32'd3) begin errors++; $display("FAIL divu_lo got=%h exp=00000003", LO); end
    checks++; if (HI !== 32'd1) begin errors++; $display("FAIL divu_hi got=%h exp=00000001", HI); end
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(32'd1, 32'd3, cyc, bad);
    checks++; if (LO !== 32'h8000_0000 || HI !== 32'd0) begin
      errors++; $display("FAIL div_overflow got hi=%h lo=%h exp hi=00000000 lo=80000000", HI, LO);
    end
  endtask

  task automatic test_div_zero;
    int cyc, bad;
    issue(3'd4, 32'hAAAA_0000, 32'd0);
    issue(3'd5, 32'h0000_BBBB, 32'd0);
    issue(3'd3, 32'd55, 32'd0);
    wait_done(32'hAAAA_0000, 32'h0000_BBBB, cyc, bad);
    checks++; if (cyc !== 10) begin errors++; $display("FAIL divz_latency got=%0d exp=10", cyc); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL divz_hold got=%0d bad samples exp=0", bad); end
    checks++; if (HI !== 32'hAAAA_0000) begin errors++; $display("FAIL divz_hi got=%h exp=aaaa0000", HI); end
    checks++; if (LO !== 32'h0000_BBBB) begin errors++; $display("FAIL divz_lo got=%h exp=0000bbbb", LO); end
  endtask

  task automatic test_start_ignored;
    int cyc, bad;
    issue(3'd0, 32'd3, 32'd4);
    @(negedge clk);
    issue(3'd2, 32'd9, 32'd3);
    wait_done(32'hAAAA_0000, 32'h0000_BBBB, cyc, bad);
    checks++; if (cyc + 2 !== 5) begin errors++; $display("FAIL ignore_latency got=%0d exp=5", cyc + 2); end
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL ignore_hi got=%h exp=00000000", HI); end
    checks++; if (LO !== 32'd12) begin errors++; $display("FAIL ignore_lo got=%h exp=0000000c", LO); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid_run;
    int bad;
    issue(3'd4, 32'h0000_0055, 32'd0);
    issue(3'd5, 32'h0000_0066, 32'd0);
    issue(3'd2, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got=%b exp=1", busy); end
    #2 reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || dbg_state !== 1'b0) begin
      errors++; $display("FAIL rst_async_busy got busy=%b state=%b exp 0/0", busy, dbg_state);
    end
    checks++; if (HI !== 32'd0 || LO !== 32'd0) begin
      errors++; $display("FAIL rst_async_hilo got hi=%h lo=%h exp 0/0", HI, LO);
    end
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (HI !== 32'd0 || LO !== 32'd0 || busy !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rst_no_late_commit got=%0d bad cycles exp=0 (hi=%h lo=%h)", bad, HI, LO); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu_mthi();
    test_div_back_to_back();
    test_div_zero();
    test_start_ignored();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
